// File: rtl/ysyx_040978_divctl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040978_divctl
// Description : Front/back end around the iterative divider ysyx_040978_diver.
//               Optional last-result cache: DIVCTL_RESULT_CACHE_EN.
// Revision    : 1.0
// ============================================================================

module ysyx_040978_divctl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            div_in_valid,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  localparam logic [XLEN-1:0] c_MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_signed;
  logic            r_word;
  logic            r_rem;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic [XLEN-1:0] r_resp_data;

  logic            w_signed;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic            w_accept;
  logic [XLEN-1:0] w_sp_res;
  logic [XLEN-1:0] w_div_res;
  logic            w_div_done;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_res;

  function automatic logic [XLEN-1:0] sel_res(input logic rem, input logic word,
                                              input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r);
    logic [XLEN-1:0] res;
    res = rem ? r : q;
    return word ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  endfunction

  function automatic logic [XLEN-1:0] prep(input logic sgn, input logic word,
                                           input logic [XLEN-1:0] src);
    if (!word)
      return src;
    return sgn ? {{(XLEN-32){src[31]}}, src[31:0]} : {{(XLEN-32){1'b0}}, src[31:0]};
  endfunction

  assign w_signed  = ~req_op[0];
  assign w_src1    = prep(w_signed, req_word, req_src1);
  assign w_src2    = prep(w_signed, req_word, req_src2);
  assign w_div0    = (w_src2 == '0);
  assign w_ovf     = w_signed & (w_src1 == (req_word ? c_MIN_W : c_MIN_D)) & (&w_src2);
  assign w_special = w_div0 | w_ovf;
  assign w_accept  = req_valid & (r_state == S_IDLE) & ~flush;
  assign w_sp_res  = sel_res(req_op[1], req_word,
                             w_div0 ? {XLEN{1'b1}} : w_src1,
                             w_div0 ? w_src1 : '0);
  assign w_div_res  = sel_res(r_rem, r_word, div_quotient, div_remainder);
  // Only a completion that is actually delivered counts; flush wins.
  assign w_div_done = (r_state == S_WAIT) & div_out_valid & ~flush;

`ifdef DIVCTL_RESULT_CACHE_EN
  logic            r_c_valid;
  logic            r_c_signed;
  logic            r_c_word;
  logic [XLEN-1:0] r_c_src1;
  logic [XLEN-1:0] r_c_src2;
  logic [XLEN-1:0] r_c_q;
  logic [XLEN-1:0] r_c_r;

  assign w_hit = r_c_valid & (r_c_signed == w_signed) & (r_c_word == req_word) &
                 (r_c_src1 == w_src1) & (r_c_src2 == w_src2);
  assign w_hit_res = sel_res(req_op[1], req_word, r_c_q, r_c_r);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_c_valid  <= 1'b0;
      r_c_signed <= 1'b0;
      r_c_word   <= 1'b0;
      r_c_src1   <= '0;
      r_c_src2   <= '0;
      r_c_q      <= '0;
      r_c_r      <= '0;
    end else if (w_div_done) begin
      r_c_valid  <= 1'b1;
      r_c_signed <= r_signed;
      r_c_word   <= r_word;
      r_c_src1   <= r_src1;
      r_c_src2   <= r_src2;
      r_c_q      <= div_quotient;
      r_c_r      <= div_remainder;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = (w_special | w_hit) ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        // A flush coinciding with the completion has nothing left to drain.
        if (flush)              w_state_nxt = div_out_valid ? S_IDLE : S_DRAIN;
        else if (div_out_valid) w_state_nxt = S_DONE;
      end
      S_DONE:   if (flush || resp_ready) w_state_nxt = S_IDLE;
      S_DRAIN:  if (div_out_valid) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_signed    <= 1'b0;
      r_word      <= 1'b0;
      r_rem       <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_signed <= w_signed;
        r_word   <= req_word;
        r_rem    <= req_op[1];
        r_src1   <= w_src1;
        r_src2   <= w_src2;
        if (w_special)
          r_resp_data <= w_sp_res;
        else if (w_hit)
          r_resp_data <= w_hit_res;
      end
      if (w_div_done)
        r_resp_data <= w_div_res;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_DONE);
  assign resp_data    = r_resp_data;
  assign div_in_valid = (r_state == S_LAUNCH);
  assign div_signed   = r_signed;
  assign div_dividend = r_src1;
  assign div_divisor  = r_src2;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_040978_divctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_040978_divctl
// Description : Directed self-checking bench with a behavioural divider.
// Revision    : 1.0
// ============================================================================

module tb_ysyx_040978_divctl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_word = 1'b0;
  logic [63:0] req_src1 = '0;
  logic [63:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        div_in_valid;
  logic        div_signed;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic        div_out_valid = 1'b0;
  logic [63:0] div_quotient = '0;
  logic [63:0] div_remainder = '0;

  int tests = 0;
  int fails = 0;

  ysyx_040978_divctl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_in_valid(div_in_valid), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

  // Behavioural divider: fixed latency, single-cycle out_valid pulse.
  int          launches = 0;
  int          completions = 0;
  int          iv_neg = 0;
  int          cnt = 0;
  logic        busy = 1'b0;
  logic [63:0] pq = '0, pr = '0;
  logic [63:0] last_a = '0, last_b = '0;
  logic        last_s = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      cnt <= 0;
      div_out_valid <= 1'b0;
    end else begin
      div_out_valid <= 1'b0;
      if (div_out_valid) completions <= completions + 1;
      if (div_in_valid) begin
        busy <= 1'b1;
        cnt <= 4;
        launches <= launches + 1;
        last_a <= div_dividend;
        last_b <= div_divisor;
        last_s <= div_signed;
        if (div_divisor == 64'd0) begin
          pq <= '1;
          pr <= div_dividend;
        end else if (div_signed) begin
          pq <= $signed(div_dividend) / $signed(div_divisor);
          pr <= $signed(div_dividend) % $signed(div_divisor);
        end else begin
          pq <= div_dividend / div_divisor;
          pr <= div_dividend % div_divisor;
        end
      end else if (busy) begin
        if (cnt == 1) begin
          busy <= 1'b0;
          div_out_valid <= 1'b1;
          div_quotient <= pq;
          div_remainder <= pr;
        end
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clock) if (div_in_valid) iv_neg <= iv_neg + 1;

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, b);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_word = w; req_src1 = a; req_src2 = b;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [63:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) begin ok = 1'b1; d = resp_data; break; end
      @(negedge clock);
    end
  endtask

  task automatic consume();
    @(negedge clock); resp_ready = 1'b1;
    @(negedge clock); resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0) begin
      fails++;
      $display("FAIL reset_hs: ready=%b valid=%b data=%h want 1 0 0", req_ready, resp_valid, resp_data);
    end
    tests++;
    if (div_in_valid !== 1'b0 || div_signed !== 1'b0 || div_dividend !== 64'd0 || div_divisor !== 64'd0) begin
      fails++;
      $display("FAIL reset_div: iv=%b s=%b a=%h b=%h want all 0", div_in_valid, div_signed, div_dividend, div_divisor);
    end
    reset = 1'b0;
  endtask

  task automatic test_div_signed();
    logic [63:0] d; bit ok; int l0, i0;
    l0 = launches; i0 = iv_neg;
    issue(2'b00, 1'b0, 64'd100, -64'sd7);
    tests++;
    if (div_in_valid !== 1'b1 || req_ready !== 1'b0 || div_signed !== 1'b1 || div_dividend !== 64'd100) begin
      fails++;
      $display("FAIL div_launch: iv=%b rdy=%b s=%b a=%h want 1 0 1 64", div_in_valid, req_ready, div_signed, div_dividend);
    end
    wait_resp(d, ok);
    tests++;
    if (!ok || d !== 64'hFFFF_FFFF_FFFF_FFF2) begin
      fails++;
      $display("FAIL div_100_m7: ok=%b got %h want fffffffffffffff2", ok, d);
    end
    tests++;
    if (launches - l0 !== 1 || iv_neg - i0 !== 1) begin
      fails++;
      $display("FAIL div_pulse: launches=%0d iv_cycles=%0d want 1 1", launches - l0, iv_neg - i0);
    end
    consume();
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL div_consume: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_special();
    int l0;
    l0 = launches;
    issue(2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'd0);
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h8000_0000_0000_0000) begin
      fails++;
      $display("FAIL remu_by0: valid=%b got %h want 1 8000000000000000", resp_valid, resp_data);
    end
    consume();
    issue(2'b00, 1'b0, 64'd5, 64'd0);
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++;
      $display("FAIL div_by0: valid=%b got %h want 1 ffffffffffffffff", resp_valid, resp_data);
    end
    consume();
    issue(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_8000_0000) begin
      fails++;
      $display("FAIL divw_ovf: valid=%b got %h want 1 ffffffff80000000", resp_valid, resp_data);
    end
    consume();
    issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h8000_0000_0000_0000) begin
      fails++;
      $display("FAIL div_ovf: valid=%b got %h want 1 8000000000000000", resp_valid, resp_data);
    end
    consume();
    issue(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'd0) begin
      fails++;
      $display("FAIL rem_ovf: valid=%b got %h want 1 0", resp_valid, resp_data);
    end
    consume();
    tests++;
    if (launches !== l0) begin
      fails++;
      $display("FAIL special_nolaunch: launches=%0d want %0d", launches, l0);
    end
  endtask

  task automatic test_word();
    logic [63:0] d; bit ok;
    issue(2'b01, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0001);
    wait_resp(d, ok);
    tests++;
    if (last_a !== 64'h0000_0000_FFFF_FFFF || last_b !== 64'd1 || last_s !== 1'b0) begin
      fails++;
      $display("FAIL divuw_ops: a=%h b=%h s=%b want 00000000ffffffff 1 0", last_a, last_b, last_s);
    end
    tests++;
    if (!ok || d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++;
      $display("FAIL divuw_res: ok=%b got %h want ffffffffffffffff", ok, d);
    end
    consume();
    issue(2'b10, 1'b1, 64'h5555_5555_FFFF_FFEF, 64'h0000_0001_0000_0005);
    wait_resp(d, ok);
    tests++;
    if (last_a !== 64'hFFFF_FFFF_FFFF_FFEF || last_b !== 64'd5 || last_s !== 1'b1) begin
      fails++;
      $display("FAIL remw_ops: a=%h b=%h s=%b want ffffffffffffffef 5 1", last_a, last_b, last_s);
    end
    tests++;
    if (!ok || d !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      fails++;
      $display("FAIL remw_res: ok=%b got %h want fffffffffffffffe", ok, d);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [63:0] d; bit ok; bit early; int c0;
    issue(2'b00, 1'b0, 64'd1000, 64'd3);
    c0 = completions;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    req_valid = 1'b1; req_op = 2'b10; req_word = 1'b0; req_src1 = 64'd17; req_src2 = 64'd5;
    early = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (resp_valid) early = 1'b1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || completions !== c0 + 1 || early) begin
      fails++;
      $display("FAIL flush_drain: ready=%b completions=%0d want %0d early_resp=%b", ok, completions - c0, 1, early);
    end
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp(d, ok);
    tests++;
    if (!ok || d !== 64'd2) begin
      fails++;
      $display("FAIL flush_rem: ok=%b got %h want 2", ok, d);
    end
    consume();
    repeat (3) @(negedge clock);
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_extra: valid=%b want 0", resp_valid);
    end
    // Kill a response already sitting in DONE.
    issue(2'b00, 1'b0, 64'd9, 64'd0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_done: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    // Flush while idle blocks acceptance.
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 64'd9; req_src2 = 64'd0; flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_idle: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; bit ok; bit unstable; int l0;
    issue(2'b00, 1'b0, 64'd100, 64'd7);
    wait_resp(d, ok);
    unstable = !ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== 64'd14) unstable = 1'b1;
    end
    tests++;
    if (unstable) begin
      fails++;
      $display("FAIL stall_hold: valid=%b got %h want 1 000000000000000e", resp_valid, resp_data);
    end
    // Response consumed while a request waits: no same-cycle accept.
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'b11; req_word = 1'b0; req_src1 = 64'h1234; req_src2 = 64'd0;
    @(negedge clock);
    resp_ready = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_noaccept: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h1234) begin
      fails++;
      $display("FAIL b2b_next: valid=%b got %h want 1 1234", resp_valid, resp_data);
    end
    consume();
    l0 = launches;
    issue(2'b10, 1'b0, 64'd100, 64'd7);
`ifdef DIVCTL_RESULT_CACHE_EN
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 64'd2 || launches !== l0 || div_in_valid !== 1'b0) begin
      fails++;
      $display("FAIL cache_hit: valid=%b got %h launches=%0d want 1 2 0", resp_valid, resp_data, launches - l0);
    end
`else
    wait_resp(d, ok);
    tests++;
    if (!ok || d !== 64'd2 || launches - l0 !== 1) begin
      fails++;
      $display("FAIL rem_100_7: ok=%b got %h launches=%0d want 2 1", ok, d, launches - l0);
    end
`endif
    consume();
  endtask

  task automatic test_reset_mid();
    issue(2'b00, 1'b0, 64'd55, 64'd5);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || div_in_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b ready=%b iv=%b want 0 1 0", resp_valid, req_ready, div_in_valid);
    end
    repeat (10) @(negedge clock);
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_resp: valid=%b want 0", resp_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_div_signed();
    test_special();
    test_word();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
